// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: sizing helpers, default geometry
// and the per-cycle operation encoding used by the control logic.
package fifo_pkg;

    localparam int FIFO_DEF_DATA_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH      = 16;

    // Encoding is {write accepted, read accepted} so the enum can be cast
    // straight from the two accept strobes.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int fifo_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Pointer width: address bits plus one wrap bit to tell full from empty.
    function automatic int fifo_ptr_w(input int depth);
        return fifo_clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

    // Write port: store on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and one-cycle overflow/underflow pulses.
// Build option: FIFO_FWFT_EN selects first-word fall-through output; when
// undefined, data_out is a register loaded one cycle after an accepted read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DEF_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEF_DEPTH,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    localparam int PW        = fifo_ptr_w(DEPTH),
    localparam int AW        = PW - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [AW:0]           count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_CNT = (AW+1)'(AE_LEVEL);

    logic [AW:0]           wr_ptr, rd_ptr, count_q;
    logic [AW:0]           wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic                  full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic                  full_nxt, empty_nxt;
    logic                  wr_ok, rd_ok;
    fifo_op_e              op;
    logic [DATA_WIDTH-1:0] mem_rd;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (data_in),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (mem_rd)
    );

    // Accept logic and next-state pointers, count and full/empty.
    // A write into a full FIFO is allowed only when a read frees the slot in
    // the same cycle; a read of an empty FIFO is never accepted.
    always_comb begin
        rd_ok      = re && !empty_q;
        wr_ok      = we && (!full_q || rd_ok);
        op         = fifo_op_e'({wr_ok, rd_ok});
        wr_ptr_nxt = wr_ok ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr_nxt = rd_ok ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt  = count_q;
        case (op)
            OP_WR:   count_nxt = count_q + 1'b1;
            OP_RD:   count_nxt = count_q - 1'b1;
            default: count_nxt = count_q;
        endcase
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                     (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
    end

    // Pointer, occupancy and flag registers; every flag is derived from the
    // same next state so they always agree with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            count_q <= count_nxt;
            full_q  <= full_nxt;
            empty_q <= empty_nxt;
            af_q    <= (count_nxt >= AF_CNT);
            ae_q    <= (count_nxt <= AE_CNT);
            // A concurrent read makes room, so only a lone write overflows;
            // a concurrent write into an empty FIFO is not an underflow.
            ovf_q   <= we && full_q && !re;
            unf_q   <= re && empty_q && !we;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [DATA_WIDTH-1:0] head_q;

    // Remember the most recent head so the output stays stable while empty.
    always_ff @(posedge clk) begin
        if (rst)          head_q <= '0;
        else if (!empty_q) head_q <= mem_rd;
    end

    assign data_out = empty_q ? head_q : mem_rd;
`else
    logic [DATA_WIDTH-1:0] dout_q;

    // Registered read data: loads on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst)        dout_q <= '0;
        else if (rd_ok) dout_q <= mem_rd;
    end

    assign data_out = dout_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (8 x 16, AF=14, AE=2).
module tb_fifo_sync_param;

    logic       clk = 1'b0;
    logic       rst, we, re;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] mq[$];   // reference contents
    logic [7:0] sb[$];   // expected read data awaiting the output register
    logic [7:0] last_out;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        int         cnt;
        logic       unf;
        logic [7:0] dout;
    } vec_t;

    vec_t vt[10];

    always #5 clk = ~clk;

    fifo_sync_param #(
        .DATA_WIDTH (8),
        .DEPTH      (16),
        .AF_LEVEL   (14),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .data_in      (data_in),
        .re           (re),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic check_flags();
        check("count", count, mq.size());
        check("full", full, mq.size() == 16);
        check("empty", empty, mq.size() == 0);
        check("almost_full", almost_full, mq.size() >= 14);
        check("almost_empty", almost_empty, mq.size() <= 2);
    endtask

    // One clock of stimulus with reference-model prediction and checks.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        logic m_full, m_empty, racc, wacc, e_ovf, e_unf;
        logic [7:0] tmp;
        m_full  = (mq.size() == 16);
        m_empty = (mq.size() == 0);
        racc    = r && !m_empty;
        wacc    = w && (!m_full || racc);
        e_ovf   = w && m_full && !r;
        e_unf   = r && m_empty && !w;
`ifdef FIFO_FWFT_EN
        if (racc) begin
            check("fwft_pop_data", data_out, mq[0]);
            tmp = mq.pop_front();
        end
`else
        if (racc) begin
            tmp = mq.pop_front();
            sb.push_back(tmp);
        end
`endif
        if (wacc) mq.push_back(d);
        we = w; re = r; data_in = d;
        @(posedge clk); #1;
        we = 1'b0; re = 1'b0;
`ifdef FIFO_FWFT_EN
        if (mq.size() != 0) check("fwft_head", data_out, mq[0]);
`else
        if (racc) last_out = sb.pop_front();
        check("data_out", data_out, last_out);
`endif
        check("overflow", overflow, e_ovf);
        check("underflow", underflow, e_unf);
        check_flags();
    endtask

    task automatic do_reset(input logic w);
        rst = 1'b1; we = w; re = 1'b0; data_in = 8'hEE;
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0;
        mq.delete(); sb.delete(); last_out = 8'h00;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_dout", data_out, 0);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; data_in = 8'h00; last_out = 8'h00;
        @(posedge clk); #1;
        do_reset(1'b0);

        // Idle after reset keeps the reset state.
        step(0, 0, 8'h00);

        // Short table: underflow, write+read on empty, mixed traffic.
        vt[0] = '{0, 1, 8'h00, 0, 1, 8'h00};
        vt[1] = '{1, 1, 8'h11, 1, 0, 8'h00};
        vt[2] = '{0, 1, 8'h00, 0, 0, 8'h11};
        vt[3] = '{0, 0, 8'h00, 0, 0, 8'h11};
        vt[4] = '{1, 0, 8'h22, 1, 0, 8'h11};
        vt[5] = '{1, 0, 8'h33, 2, 0, 8'h11};
        vt[6] = '{0, 1, 8'h00, 1, 0, 8'h22};
        vt[7] = '{1, 1, 8'h44, 1, 0, 8'h33};
        vt[8] = '{0, 1, 8'h00, 0, 0, 8'h44};
        vt[9] = '{0, 1, 8'h00, 0, 1, 8'h44};
        for (int i = 0; i < 10; i++) begin
            step(vt[i].we, vt[i].re, vt[i].din);
            check("tbl_count", count, vt[i].cnt);
            check("tbl_unf", underflow, vt[i].unf);
`ifndef FIFO_FWFT_EN
            check("tbl_dout", data_out, vt[i].dout);
`endif
        end

        // Fill 0x00..0x0F; almost_full must rise at the 14th write.
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 8'(i));
            check("af_edge", almost_full, i >= 13);
        end
        check("fill_full", full, 1);

        // Overflow on full: one-cycle pulse, 0xAA dropped.
        step(1, 0, 8'hAA);
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 16);
        step(0, 0, 8'h00);
        check("ovf_clear", overflow, 0);

        // Full with simultaneous read/write for 40 cycles: stays full, wraps.
        for (int i = 0; i < 40; i++) begin
            step(1, 1, 8'(8'h80 + i));
            check("rw_full", full, 1);
        end

        // Drain everything; order is checked by the scoreboard.
        for (int i = 0; i < 16; i++) step(0, 1, 8'h00);
        check("drain_empty", empty, 1);
        check("sb_drained", sb.size(), 0);

        // Reset with 9 entries (and a write pending) discards everything.
        for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h30 + i));
        check("pre_rst_count", count, 9);
        do_reset(1'b1);
        step(0, 0, 8'h00);

        // Write to empty without reading.
        step(1, 0, 8'h5A);
`ifdef FIFO_FWFT_EN
        check("fwft_5a", data_out, 8'h5A);
`else
        check("std_no_fallthrough", data_out, 8'h00);
`endif
        step(0, 1, 8'h00);
        check("final_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
